// File: rtl/wallace_pipe_if.sv
// Handshake bundle for the carry-save reduction tree: input rows with tag
// and flush on one side, reduced sum/carry pair with tag on the other.
//   master: producer/consumer side (drives rows, flush, Out_ready_SI)
//   slave : the reduction tree itself
interface wallace_pipe_if #(
    parameter int C_WIDTH  = 49,
    parameter int C_NUM_PP = 13,
    parameter int C_TAG_W  = 4
);
    logic                          Flush_SI;
    logic                          In_valid_SI;
    logic                          In_ready_SO;
    logic [C_NUM_PP*C_WIDTH-1:0]   Pp_DI;
    logic [C_TAG_W-1:0]            Tag_DI;
    logic                          Out_valid_SO;
    logic                          Out_ready_SI;
    logic [C_WIDTH-1:0]            Pp_sum_DO;
    logic [C_WIDTH-1:0]            Pp_carry_DO;
    logic                          MSB_cor_DO;
    logic [C_TAG_W-1:0]            Tag_DO;

    modport master (
        output Flush_SI, In_valid_SI, Pp_DI, Tag_DI, Out_ready_SI,
        input  In_ready_SO, Out_valid_SO, Pp_sum_DO, Pp_carry_DO,
               MSB_cor_DO, Tag_DO
    );

    modport slave (
        input  Flush_SI, In_valid_SI, Pp_DI, Tag_DI, Out_ready_SI,
        output In_ready_SO, Out_valid_SO, Pp_sum_DO, Pp_carry_DO,
               MSB_cor_DO, Tag_DO
    );
endinterface

// File: rtl/wallace_pipe.sv
// Pipelined 3:2 carry-save reduction tree: C_NUM_PP rows -> sum/carry pair.
// Ports: Clk_CI, Rst_RI (sync, active high), bus (wallace_pipe_if.slave):
//   rows+tag in with valid/ready and flush; sum, unshifted carry, MSB
//   correction flag and tag out with valid/ready.
module wallace_pipe #(
    parameter int C_WIDTH  = 49,
    parameter int C_NUM_PP = 13,
    parameter int C_STAGES = 2,
    parameter int C_TAG_W  = 4
) (
    input logic           Clk_CI,
    input logic           Rst_RI,
    wallace_pipe_if.slave bus
);

    function automatic int next_rows(input int r);
        return 2 * (r / 3) + r % 3;
    endfunction

    function automatic int num_levels();
        int r = C_NUM_PP;
        int n = 0;
        while (r > 2) begin
            r = next_rows(r);
            n++;
        end
        return n;
    endfunction

    localparam int C_LEVELS = num_levels();

    function automatic int rows_at(input int l);
        int r = C_NUM_PP;
        for (int i = 0; i < l; i++) r = next_rows(r);
        return r;
    endfunction

    // Stage k sits after level ceil(k*L/S); 0 means no register there.
    function automatic int stage_at(input int l);
        int s = 0;
        for (int k = 1; k <= C_STAGES; k++)
            if ((k * C_LEVELS + C_STAGES - 1) / C_STAGES == l) s = k;
        return s;
    endfunction

    typedef logic [C_NUM_PP-1:0][C_WIDTH-1:0] rows_t;

    // Node l is the state after tree level l (node 0 = block input).
    rows_t              nd_rows [0:C_LEVELS];
    logic               nd_cor  [0:C_LEVELS];
    logic               nd_vld  [0:C_LEVELS];
    logic               nd_rdy  [0:C_LEVELS];
    logic [C_TAG_W-1:0] nd_tag  [0:C_LEVELS];

    assign nd_rows[0]        = bus.Pp_DI;
    assign nd_cor[0]         = 1'b0;
    assign nd_vld[0]         = bus.In_valid_SI;
    assign nd_tag[0]         = bus.Tag_DI;
    assign nd_rdy[C_LEVELS]  = bus.Out_ready_SI;

    generate
        for (genvar l = 1; l <= C_LEVELS; l++) begin : g_lvl
            localparam int R  = rows_at(l - 1);
            localparam int G  = R / 3;
            localparam int RN = next_rows(R);
            localparam int S  = stage_at(l);
            localparam bit LAST = (l == C_LEVELS);

            rows_t      red;
            logic [G-1:0] lost;
            logic       red_cor;
            logic       unused_lvl;

            // Rows beyond R are zero fillers of the shared array type.
            assign unused_lvl = ^nd_rows[l-1];

            for (genvar g = 0; g < G; g++) begin : g_csa
                logic [C_WIDTH-1:0] a, b, c, cy;
                assign a  = nd_rows[l-1][3*g];
                assign b  = nd_rows[l-1][3*g+1];
                assign c  = nd_rows[l-1][3*g+2];
                assign cy = (a & b) | (a & c) | (b & c);
                assign red[2*g] = a ^ b ^ c;
                if (LAST) begin : g_fin
                    // Final carry leaves unshifted; its top bit survives.
                    assign red[2*g+1] = cy;
                    assign lost[g]    = 1'b0;
                end else begin : g_mid
                    assign red[2*g+1] = {cy[C_WIDTH-2:0], 1'b0};
                    assign lost[g]    = cy[C_WIDTH-1];
                end
            end

            for (genvar j = 2 * G; j < C_NUM_PP; j++) begin : g_pass
                if (j < RN) begin : g_row
                    assign red[j] = nd_rows[l-1][j + G];
                end else begin : g_zero
                    assign red[j] = '0;
                end
            end

            assign red_cor = nd_cor[l-1] | (|lost);

            if (S == 0) begin : g_comb
                assign nd_rows[l]  = red;
                assign nd_cor[l]   = red_cor;
                assign nd_vld[l]   = nd_vld[l-1];
                assign nd_tag[l]   = nd_tag[l-1];
                assign nd_rdy[l-1] = nd_rdy[l];
            end else begin : g_reg
                rows_t              rows_q;
                logic               cor_q;
                logic               vld_q;
                logic [C_TAG_W-1:0] tag_q;
                logic               load;

                assign nd_rdy[l-1] = !vld_q || nd_rdy[l];
                assign load        = nd_vld[l-1] && nd_rdy[l-1];

                always_ff @(posedge Clk_CI) begin
                    if (Rst_RI) begin
                        vld_q  <= 1'b0;
                        rows_q <= '0;
                        cor_q  <= 1'b0;
                        tag_q  <= '0;
                    end else if (bus.Flush_SI) begin
                        vld_q <= 1'b0;
                    end else begin
                        if (nd_rdy[l-1]) vld_q <= nd_vld[l-1];
                        // Data moves only on a real transfer.
                        if (load) begin
                            rows_q <= red;
                            cor_q  <= red_cor;
                            tag_q  <= nd_tag[l-1];
                        end
                    end
                end

                assign nd_rows[l] = rows_q;
                assign nd_cor[l]  = cor_q;
                assign nd_vld[l]  = vld_q;
                assign nd_tag[l]  = tag_q;
            end
        end

        if (C_STAGES == 0) begin : g_nopipe
            logic unused_ctl;
            assign unused_ctl      = Clk_CI ^ Rst_RI ^ bus.Flush_SI;
            assign bus.In_ready_SO = nd_rdy[0];
        end else begin : g_pipe
            assign bus.In_ready_SO = nd_rdy[0] && !bus.Flush_SI;
        end
    endgenerate

    logic unused_out;
    assign unused_out = ^nd_rows[C_LEVELS];

    assign bus.Out_valid_SO = nd_vld[C_LEVELS];
    assign bus.Pp_sum_DO    = nd_rows[C_LEVELS][0];
    assign bus.Pp_carry_DO  = nd_rows[C_LEVELS][1];
    assign bus.MSB_cor_DO   = nd_cor[C_LEVELS];
    assign bus.Tag_DO       = nd_tag[C_LEVELS];

endmodule

// File: tb/tb_wallace_pipe.sv
// Bench for wallace_pipe: 13x49 two-stage tree plus 4x16 trees
// (combinational and fully staged) against a modular-sum reference.
module tb_wallace_pipe;
    localparam int W   = 49;
    localparam int NPP = 13;
    localparam int TW  = 4;
    localparam int W2  = 16;
    localparam int NP2 = 4;
    localparam int TW2 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wallace_pipe_if #(.C_WIDTH(W), .C_NUM_PP(NPP), .C_TAG_W(TW)) a();
    wallace_pipe_if #(.C_WIDTH(W2), .C_NUM_PP(NP2), .C_TAG_W(TW2)) b();
    wallace_pipe_if #(.C_WIDTH(W2), .C_NUM_PP(NP2), .C_TAG_W(TW2)) c();

    wallace_pipe #(.C_WIDTH(W), .C_NUM_PP(NPP), .C_STAGES(2), .C_TAG_W(TW))
        u_a (.Clk_CI(clk), .Rst_RI(rst), .bus(a.slave));
    wallace_pipe #(.C_WIDTH(W2), .C_NUM_PP(NP2), .C_STAGES(0), .C_TAG_W(TW2))
        u_b (.Clk_CI(clk), .Rst_RI(rst), .bus(b.slave));
    wallace_pipe #(.C_WIDTH(W2), .C_NUM_PP(NP2), .C_STAGES(2), .C_TAG_W(TW2))
        u_c (.Clk_CI(clk), .Rst_RI(rst), .bus(c.slave));

    typedef struct {
        logic [NPP*W-1:0] pp;
        logic [TW-1:0]    tag;
        logic [W-1:0]     exp;
        logic             cor;
        logic             chk_cor;
    } vec_t;

    typedef struct {
        logic [W-1:0]  exp;
        logic [TW-1:0] tag;
        logic          cor;
        logic          chk_cor;
        int            cyc;
    } sb_t;

    typedef struct {
        logic [W2-1:0]  exp;
        logic [TW2-1:0] tag;
    } sb2_t;

    vec_t txq[$];
    sb_t  sb[$];
    sb2_t q2[$];
    vec_t tbl[6];

    int n_vec   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    bit lat_chk = 0;
    bit rnd     = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [W-1:0] ref_sum(input logic [NPP*W-1:0] pp);
        logic [W-1:0] s = '0;
        for (int i = 0; i < NPP; i++) s = s + pp[i*W +: W];
        return s;
    endfunction

    function automatic logic [W2-1:0] ref_sum2(input logic [NP2*W2-1:0] pp);
        logic [W2-1:0] s = '0;
        for (int i = 0; i < NP2; i++) s = s + pp[i*W2 +: W2];
        return s;
    endfunction

    function automatic logic [NPP*W-1:0] fill(input logic [W-1:0] v,
                                              input logic [NPP-1:0] m);
        logic [NPP*W-1:0] r;
        for (int i = 0; i < NPP; i++) r[i*W +: W] = m[i] ? v : '0;
        return r;
    endfunction

    function automatic logic [NPP*W-1:0] rnd_pp();
        logic [NPP*W-1:0] r;
        for (int i = 0; i < NPP; i++)
            r[i*W +: W] = ($urandom_range(0, 3) == 0) ? {W{1'b1}}
                        : W'({$urandom(), $urandom()});
        return r;
    endfunction

    function automatic vec_t rnd_vec(input logic [TW-1:0] tag);
        vec_t v;
        v.pp      = rnd_pp();
        v.tag     = tag;
        v.exp     = ref_sum(v.pp);
        v.cor     = 1'b0;
        v.chk_cor = 1'b0;
        return v;
    endfunction

    // One clock of the 13-row DUT: check/accept at negedge, drive after posedge.
    task automatic step();
        sb_t          e;
        logic [W-1:0] s;
        @(negedge clk);
        cyc++;
        if (rst || a.Flush_SI) begin
            sb.delete();
        end else begin
            if (a.Out_valid_SO && a.Out_ready_SI) begin
                if (sb.size() == 0) fail_now("unexpected_output");
                else begin
                    e = sb.pop_front();
                    s = a.Pp_sum_DO + {a.Pp_carry_DO[W-2:0], 1'b0};
                    chk("sum", 64'(s), 64'(e.exp));
                    chk("tag", 64'(a.Tag_DO), 64'(e.tag));
                    if (e.chk_cor)
                        chk("msb_cor", 64'(a.MSB_cor_DO), 64'(e.cor));
                    if (lat_chk)
                        chk("latency", 64'(cyc - e.cyc), 64'd2);
                end
            end
            if (a.In_valid_SI && a.In_ready_SO) begin
                e.exp     = txq[0].exp;
                e.tag     = txq[0].tag;
                e.cor     = txq[0].cor;
                e.chk_cor = txq[0].chk_cor;
                e.cyc     = cyc;
                sb.push_back(e);
                void'(txq.pop_front());
                acc_cnt++;
            end
        end
        @(posedge clk);
        #1;
        if (rnd) a.Out_ready_SI = ($urandom_range(0, 3) != 0);
        if (txq.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            a.In_valid_SI = 1'b1;
            a.Pp_DI       = txq[0].pp;
            a.Tag_DI      = txq[0].tag;
        end else begin
            a.In_valid_SI = 1'b0;
        end
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && (txq.size() > 0 || sb.size() > 0); i++)
            step();
        chk("drain_left", 64'(txq.size() + sb.size()), 64'd0);
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_out_valid"}, 64'(a.Out_valid_SO), 64'd0);
        chk({pfx, "_sum"}, 64'(a.Pp_sum_DO), 64'd0);
        chk({pfx, "_carry"}, 64'(a.Pp_carry_DO), 64'd0);
        chk({pfx, "_cor"}, 64'(a.MSB_cor_DO), 64'd0);
        chk({pfx, "_tag"}, 64'(a.Tag_DO), 64'd0);
        chk({pfx, "_in_ready"}, 64'(a.In_ready_SO), 64'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t          v;
        sb2_t          e2;
        logic [W-1:0]  s;
        logic [W-1:0]  exp0;
        logic [W2-1:0] s2;

        rst = 1'b1;
        a.Flush_SI = 0; a.In_valid_SI = 0; a.Pp_DI = '0; a.Tag_DI = '0;
        a.Out_ready_SI = 1;
        b.Flush_SI = 0; b.In_valid_SI = 0; b.Pp_DI = '0; b.Tag_DI = '0;
        b.Out_ready_SI = 1;
        c.Flush_SI = 0; c.In_valid_SI = 0; c.Pp_DI = '0; c.Tag_DI = '0;
        c.Out_ready_SI = 1;

        tbl[0] = '{fill(49'd1, 13'h1fff), 4'd1, 49'd13, 1'b0, 1'b1};
        tbl[1] = '{fill({W{1'b1}}, 13'h1fff), 4'd2,
                   49'h1_FFFF_FFFF_FFF3, 1'b1, 1'b1};
        tbl[2] = '{fill(49'h1_0000_0000_0000, 13'h0007), 4'd3,
                   49'h1_0000_0000_0000, 1'b1, 1'b1};
        tbl[3] = '{fill(49'h1_0000_0000_0000, 13'h0001), 4'd4,
                   49'h1_0000_0000_0000, 1'b0, 1'b1};
        tbl[4] = '{fill(49'h1_0000_0000_0000, 13'h1000), 4'd5,
                   49'h1_0000_0000_0000, 1'b0, 1'b1};
        tbl[5] = '{'0, 4'd6, 49'd78, 1'b0, 1'b1};
        for (int i = 0; i < NPP; i++) tbl[5].pp[i*W +: W] = W'(i);

        step();
        step();
        rst = 1'b0;
        chk_zero_outputs("reset");

        // Table vectors back to back, fixed latency.
        lat_chk = 1;
        for (int i = 0; i < 6; i++) txq.push_back(tbl[i]);
        drain(60);
        lat_chk = 0;

        // Stall: only two items fit, output holds item 0.
        a.Out_ready_SI = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) txq.push_back(rnd_vec(TW'(i)));
        exp0 = txq[0].exp;
        repeat (6) step();
        chk("stall_accepted", 64'(acc_cnt), 64'd2);
        chk("stall_in_ready", 64'(a.In_ready_SO), 64'd0);
        chk("stall_out_valid", 64'(a.Out_valid_SO), 64'd1);
        chk("stall_hold_tag", 64'(a.Tag_DO), 64'd0);
        s = a.Pp_sum_DO + {a.Pp_carry_DO[W-2:0], 1'b0};
        chk("stall_hold_sum", 64'(s), 64'(exp0));
        repeat (2) step();
        chk("stall_hold_tag2", 64'(a.Tag_DO), 64'd0);
        a.Out_ready_SI = 1'b1;
        drain(60);

        // Flush with two items in flight.
        a.Out_ready_SI = 1'b0;
        txq.push_back(rnd_vec(4'd8));
        txq.push_back(rnd_vec(4'd9));
        repeat (4) step();
        a.Flush_SI = 1'b1;
        #1;
        chk("flush_in_ready", 64'(a.In_ready_SO), 64'd0);
        step();
        a.Flush_SI = 1'b0;
        chk("flush_out_valid", 64'(a.Out_valid_SO), 64'd0);
        a.Out_ready_SI = 1'b1;
        lat_chk = 1;
        v = tbl[1];
        v.tag = 4'd10;
        txq.push_back(v);
        drain(60);
        lat_chk = 0;

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) txq.push_back(rnd_vec(TW'(11 + i)));
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        txq.delete();
        a.In_valid_SI = 1'b0;
        chk_zero_outputs("midrst");
        repeat (4) step();

        // Random traffic with random stalls and gaps.
        rnd = 1;
        for (int i = 0; i < 300; i++) txq.push_back(rnd_vec(TW'($urandom)));
        drain(4000);
        rnd = 0;
        a.Out_ready_SI = 1'b1;

        // 4-row combinational tree.
        for (int i = 0; i < 2000; i++) begin
            b.Pp_DI        = {$urandom(), $urandom()};
            b.Tag_DI       = TW2'($urandom);
            b.In_valid_SI  = 1'($urandom);
            b.Out_ready_SI = 1'($urandom);
            b.Flush_SI     = 1'($urandom);
            #1;
            s2 = b.Pp_sum_DO + {b.Pp_carry_DO[W2-2:0], 1'b0};
            chk("comb_sum", 64'(s2), 64'(ref_sum2(b.Pp_DI)));
            chk("comb_tag", 64'(b.Tag_DO), 64'(b.Tag_DI));
            chk("comb_valid", 64'(b.Out_valid_SO), 64'(b.In_valid_SI));
            chk("comb_ready", 64'(b.In_ready_SO), 64'(b.Out_ready_SI));
        end

        // 4-row tree, one register per level, random flow.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (c.Out_valid_SO && c.Out_ready_SI) begin
                if (q2.size() == 0) fail_now("c_unexpected_output");
                else begin
                    e2 = q2.pop_front();
                    s2 = c.Pp_sum_DO + {c.Pp_carry_DO[W2-2:0], 1'b0};
                    chk("c_sum", 64'(s2), 64'(e2.exp));
                    chk("c_tag", 64'(c.Tag_DO), 64'(e2.tag));
                end
            end
            if (c.In_valid_SI && c.In_ready_SO) begin
                e2.exp = ref_sum2(c.Pp_DI);
                e2.tag = c.Tag_DI;
                q2.push_back(e2);
            end
            @(posedge clk);
            #1;
            c.In_valid_SI  = ($urandom_range(0, 3) != 0);
            c.Out_ready_SI = ($urandom_range(0, 3) != 0);
            c.Pp_DI        = {$urandom(), $urandom()};
            c.Tag_DI       = TW2'($urandom);
        end
        c.In_valid_SI  = 1'b0;
        c.Out_ready_SI = 1'b1;
        for (int i = 0; i < 20 && q2.size() > 0; i++) begin
            @(negedge clk);
            if (c.Out_valid_SO) begin
                e2 = q2.pop_front();
                s2 = c.Pp_sum_DO + {c.Pp_carry_DO[W2-2:0], 1'b0};
                chk("c_sum", 64'(s2), 64'(e2.exp));
                chk("c_tag", 64'(c.Tag_DO), 64'(e2.tag));
            end
            @(posedge clk);
        end
        chk("c_drain_left", 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
